// File: rtl/spi_rx_word_assembler_if.sv
// Byte-in / word-out bus of the SPI receive word assembler.
// A word moves on every clk edge where word_valid and word_ready are both high; word_valid never waits on word_ready.
interface spi_rx_word_assembler_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_W     = 2
);
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  cs;
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_partial;
    logic                  word_valid;
    logic                  word_ready;
    logic [ADDR_W:0]       fifo_count;
    logic                  overflow;
    logic                  clr_overflow;

    modport master (
        output byte_data, byte_ready, cs, word_ready, clr_overflow,
        input  word_data, word_partial, word_valid, fifo_count, overflow
    );

    modport slave (
        input  byte_data, byte_ready, cs, word_ready, clr_overflow,
        output word_data, word_partial, word_valid, fifo_count, overflow
    );
endinterface

// File: rtl/spi_rx_word_assembler.sv
// Packs SPI bytes MSB-first into words, flushes zero-padded tails at chip-select rise,
// and queues finished words in a show-ahead FIFO with a sticky overflow flag.
module spi_rx_word_assembler #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input logic                    clk,
    input logic                    rst,
    spi_rx_word_assembler_if.slave bus
);
    localparam int BYTES = WORD_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0]      cnt;
    logic [WORD_WIDTH-1:0] shift;
    logic [WORD_WIDTH-1:0] merged;
    logic [WORD_WIDTH-1:0] push_word;
    logic                  cs_q;
    logic [WORD_WIDTH:0]   mem [FIFO_DEPTH];
    logic [WORD_WIDTH:0]   head;
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W:0]       count;
    logic                  overflow_q;
    logic                  accept, frame_end, word_done, push;
    logic                  full, empty, pop, wr_en, drop;

    // Incoming byte drops into the slot selected by the counter; earlier slots keep their bytes.
    always_comb begin
        merged = shift;
        for (int b = 0; b < BYTES; b++) begin
            if (cnt == CNT_W'(b)) begin
                merged[WORD_WIDTH-1-8*b -: 8] = bus.byte_data;
            end
        end
    end

    assign accept    = bus.byte_ready & ~bus.cs;
    assign frame_end = ~cs_q & bus.cs;
    assign word_done = accept & (cnt == LAST);
    assign push      = word_done | (frame_end & (cnt != '0));
    assign push_word = word_done ? merged : shift;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (ADDR_W+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & bus.word_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign head  = mem[rd_ptr[ADDR_W-1:0]];

    assign bus.word_valid   = ~empty;
    assign bus.word_data    = empty ? '0 : head[WORD_WIDTH-1:0];
    assign bus.word_partial = ~empty & head[WORD_WIDTH];
    assign bus.fifo_count   = count;
    assign bus.overflow     = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shift <= '0;
            cs_q  <= 1'b1;
        end else begin
            cs_q <= bus.cs;
            if (frame_end) begin
                cnt   <= '0;
                shift <= '0;
            end else if (accept) begin
                if (word_done) begin
                    cnt   <= '0;
                    shift <= '0;
                end else begin
                    cnt   <= cnt + 1'b1;
                    shift <= merged;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow_q <= 1'b1;
            else if (bus.clr_overflow)
                overflow_q <= 1'b0;
        end
    end

    // Storage needs no reset: outputs are gated by the pointer-derived empty flag.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {frame_end, push_word};
    end
endmodule
